// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_muldiv_unit                                               |
// | Description : Iterative EX-stage multiply/divide unit. Runs MULT, MULTU,   |
// |               DIV and DIVU on the forwarded operands, one shift-add or     |
// |               restoring shift-subtract step per cycle, holds the          |
// |               architectural HI/LO pair and requests a pipeline stall when |
// |               a HI/LO consumer arrives while an operation is in flight.   |
// | Ports       : clk, rst_n (async, active low)                               |
// |               start/op/op_a/op_b : launch a mul/div (op 00 MULT, 01 MULTU, |
// |                                    10 DIV, 11 DIVU)                        |
// |               mthi/mtlo          : write op_a into HI/LO when idle         |
// |               rd_hilo            : MFHI/MFLO present in EX                 |
// |               flush              : squash the current operation            |
// |               hi/lo              : HI/LO registers                         |
// |               busy/done          : in progress / one-cycle completion      |
// |               stall_req          : hold IF/ID/EX, bubble into MEM          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  // acc: product high half / partial remainder; mq: multiplier / dividend->quotient
  logic [WIDTH-1:0] acc, mq, opnd_b, a_raw;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             is_div, neg_res, neg_rem, div_zero;

  // Operand conditioning: signed ops work on magnitudes, signs are fixed in FIN.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & op_a[WIDTH-1];
  assign b_neg     = is_signed & op_b[WIDTH-1];
  assign a_abs     = a_neg ? -op_a : op_a;
  assign b_abs     = b_neg ? -op_b : op_b;

  // One iteration of either algorithm.
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [WIDTH-1:0] acc_nxt, mq_nxt;

  always_comb begin
    mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd_b} : '0);
    rem_sh   = {acc, mq[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_b};
    acc_nxt  = acc;
    mq_nxt   = mq;
    if (is_div) begin
      // rem_sh < 2*divisor, so bit WIDTH of the difference is a clean borrow flag
      if (!rem_diff[WIDTH]) begin
        acc_nxt = rem_diff[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      mq_nxt  = {mul_sum[0], mq[WIDTH-1:1]};
    end
  end

  // Sign-corrected result, consumed during FIN.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = neg_res ? -{acc, mq} : {acc, mq};
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else if (is_div) begin
      // MIN/-1 falls out naturally: |MIN|/1 = MIN, and negating MIN is MIN
      res_lo = neg_res ? -mq  : mq;
      res_hi = neg_rem ? -acc : acc;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = CALC;
      CALC: begin
        if (flush)                   state_nxt = IDLE;
        else if (count == LAST_STEP) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd_b   <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            // squashed instruction: nothing launched, nothing written
          end else if (start) begin
            count    <= '0;
            acc      <= '0;
            mq       <= a_abs;
            opnd_b   <= b_abs;
            a_raw    <= op_a;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op[1] & (op_b == '0);
          end else begin
            if (mthi) hi_r <= op_a;
            if (mtlo) lo_r <= op_a;
          end
        end
        CALC: begin
          if (!flush) begin
            acc   <= acc_nxt;
            mq    <= mq_nxt;
            count <= count + 1'b1;
          end
        end
        FIN: begin
          if (!flush) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // The result is forwarded onto hi/lo during FIN so it is visible with done,
  // and committed at the end of FIN unless that cycle is flushed.
  assign busy      = (state != IDLE);
  assign done      = (state == FIN) & ~flush;
  assign hi        = done ? res_hi : hi_r;
  assign lo        = done ? res_lo : lo_r;
  assign stall_req = busy & (start | rd_hilo | mthi | mtlo);

endmodule
`default_nettype wire
